// File: rtl/sram_bank_ctrl.sv
// Single-port SRAM bank with a fixed-latency read pipeline and a credit-limited
// response FIFO; every accepted request returns exactly one in-order response.
module sram_bank_ctrl #(
    parameter int abits       = 12,
    parameter int log2_dbytes = 3,
    parameter int size_bytes  = 3072,
    parameter int rd_latency  = 2,
    parameter int log2_fifo   = 2
) (
    input  logic                               i_clk,
    input  logic                               i_nrst,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic [abits-1:0]                   i_req_addr,
    input  logic                               i_req_write,
    input  logic [(8<<log2_dbytes)-1:0]        i_req_wdata,
    input  logic [(1<<log2_dbytes)-1:0]        i_req_wstrb,
    output logic                               o_resp_valid,
    input  logic                               i_resp_ready,
    output logic [(8<<log2_dbytes)-1:0]        o_resp_rdata,
    output logic                               o_resp_err
);
    localparam int DW    = 8 << log2_dbytes;
    localparam int NB    = 1 << log2_dbytes;
    localparam int IW    = abits - log2_dbytes;
    localparam int WORDS = size_bytes >> log2_dbytes;
    localparam int D     = 1 << log2_fifo;
    localparam int L     = rd_latency;
    localparam logic [abits:0]       LIMIT   = (abits+1)'(size_bytes);
    localparam logic [log2_fifo:0]   D_CNT   = (log2_fifo+1)'(D);
    localparam logic [log2_fifo:0]   CNT_ONE = (log2_fifo+1)'(1);
    localparam logic [log2_fifo-1:0] PTR_ONE = (log2_fifo)'(1);

    logic [log2_fifo:0] cnt_reg;
    logic               accept;
    logic               pop;
    logic               push;
    logic               in_range;
    logic [IW-1:0]      word_idx;
    logic               unused_addr_bits;

    assign word_idx         = i_req_addr[abits-1:log2_dbytes];
    assign unused_addr_bits = ^i_req_addr[log2_dbytes-1:0];
    assign in_range         = {1'b0, i_req_addr} < LIMIT;
    assign o_req_ready      = cnt_reg < D_CNT;
    assign accept           = i_req_valid & o_req_ready;
    assign pop              = o_resp_valid & i_resp_ready;

    // Credits cover both the pipeline and the FIFO, so the FIFO cannot overflow.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt_reg <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt_reg <= cnt_reg + CNT_ONE;
                2'b01:   cnt_reg <= cnt_reg - CNT_ONE;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Word array, not reset; reads register the pre-write contents of this edge.
    logic [DW-1:0] mem [0:WORDS-1];
    logic [DW-1:0] mem_q_reg;

    always_ff @(posedge i_clk) begin
        if (accept && in_range) begin
            if (i_req_write) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_req_wstrb[b]) begin
                        mem[word_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
                    end
                end
            end else begin
                mem_q_reg <= mem[word_idx];
            end
        end
    end

    logic [L-1:0]  pv_reg;
    logic [L-1:0]  pe_reg;
    logic          pr_reg;
    logic [DW-1:0] pd [L];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pv_reg <= '0;
            pe_reg <= '0;
            pr_reg <= 1'b0;
        end else begin
            pv_reg[0] <= accept;
            pe_reg[0] <= accept & ~in_range;
            pr_reg    <= accept & in_range & ~i_req_write;
            for (int s = 1; s < L; s++) begin
                pv_reg[s] <= pv_reg[s-1];
                pe_reg[s] <= pe_reg[s-1];
            end
        end
    end

    // Stage 0 data is only meaningful for in-range reads; everything else returns zero.
    assign pd[0] = pr_reg ? mem_q_reg : '0;

    genvar gi;
    generate
        for (gi = 1; gi < L; gi++) begin : g_stage
            logic [DW-1:0] d_reg;
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    d_reg <= '0;
                end else begin
                    d_reg <= pd[gi-1];
                end
            end
            assign pd[gi] = d_reg;
        end
    endgenerate

    assign push = pv_reg[L-1];

    logic [DW-1:0]        fifo_data [0:D-1];
    logic                 fifo_err  [0:D-1];
    logic [log2_fifo-1:0] wp_reg;
    logic [log2_fifo-1:0] rp_reg;
    logic [log2_fifo:0]   fc_reg;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data[wp_reg] <= pd[L-1];
            fifo_err[wp_reg]  <= pe_reg[L-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wp_reg <= '0;
            rp_reg <= '0;
            fc_reg <= '0;
        end else begin
            if (push) begin
                wp_reg <= wp_reg + PTR_ONE;
            end
            if (pop) begin
                rp_reg <= rp_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fc_reg <= fc_reg + CNT_ONE;
                2'b01:   fc_reg <= fc_reg - CNT_ONE;
                default: fc_reg <= fc_reg;
            endcase
        end
    end

    assign o_resp_valid = (fc_reg != '0);
    assign o_resp_rdata = o_resp_valid ? fifo_data[rp_reg] : '0;
    assign o_resp_err   = o_resp_valid & fifo_err[rp_reg];
endmodule
